// File: rtl/str_rle_enc_pkg.sv
// ---------------------------------------------------------------------------
// str_rle_enc_pkg
// Shared types and default constants for the run-length encoder slice.
//   stream_unit : one sample beat (RLE_KW bytes)
//   stream_rle  : one run record {val, cnt, last} at the default widths
//   rle_state_e : encoder control states
// ---------------------------------------------------------------------------
package str_rle_enc_pkg;

    localparam int RLE_KW = 4;
    localparam int RLE_DW = RLE_KW * 8;
    localparam int RLE_CW = 32;
    localparam int RLE_TO = 16;

    typedef logic [RLE_DW-1:0] stream_unit;

    typedef struct packed {
        stream_unit        val;
        logic [RLE_CW-1:0] cnt;
        logic              last;
    } stream_rle;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        CLOSE = 2'd2
    } rle_state_e;

endpackage

// File: rtl/str_reg_out.sv
// ---------------------------------------------------------------------------
// str_reg_out
// Single-entry output holding register with valid/ready handshake.
// The parent only asserts load when the register has room, so the held
// payload never changes while m_tvalid=1 and m_tready=0.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load, din         write a new record into the register
//   m_tvalid, m_tready downstream handshake
//   dout              held record
// ---------------------------------------------------------------------------
module str_reg_out #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] dout
);

    logic         valid_r;
    logic [W-1:0] data_r;

    // Holding register: load wins, otherwise a completed transfer empties it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= din;
        end else if (m_tready) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign m_tvalid = valid_r;
    assign dout     = data_r;

endmodule

// File: rtl/str_rle_enc.sv
// ---------------------------------------------------------------------------
// str_rle_enc
// Run-length encoder for an AXI4-Stream sample path. Consecutive identical
// beats are folded into one record {value, count, last}; count is the number
// of occurrences and saturates at 2^CW-1 (the run is split there).
// Optional feature macro: STR_RLE_TIMEOUT_EN (flush an open run after TO
// idle cycles).
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   s_tvalid/s_tready/s_tdata/s_tlast sample input stream
//   m_tvalid/m_tready/m_tdata/m_tcnt/m_tlast record output stream
// ---------------------------------------------------------------------------
module str_rle_enc
    import str_rle_enc_pkg::*;
#(
    parameter int KW = RLE_KW,
    parameter int CW = RLE_CW,
    parameter int TO = RLE_TO
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tvalid,
    output logic            s_tready,
    input  logic [KW*8-1:0] s_tdata,
    input  logic            s_tlast,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [KW*8-1:0] m_tdata,
    output logic [CW-1:0]   m_tcnt,
    output logic            m_tlast
);

    localparam int DW = KW * 8;
    localparam int RW = DW + CW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // Record layout at this instance's widths (stream_rle at default widths).
    typedef struct packed {
        logic [DW-1:0] val;
        logic [CW-1:0] cnt;
        logic          last;
    } rle_t;

    rle_state_e    state_r;
    rle_state_e    state_nxt_s;
    rle_t          run_r;
    rle_t          run_nxt_s;
    rle_t          or_din_s;
    rle_t          or_dout_s;
    logic          or_load_s;
    logic          or_valid_s;
    logic          room_s;
    logic          accept_s;
    logic [CW-1:0] cnt_inc_s;
    logic          idle_fire_s;

    assign room_s    = !or_valid_s || m_tready;
    assign s_tready  = (state_r != CLOSE) && room_s;
    assign accept_s  = s_tvalid && s_tready;
    assign cnt_inc_s = run_r.cnt + CNT_ONE;

`ifdef STR_RLE_TIMEOUT_EN
    localparam int IW = $clog2(TO + 1);
    logic [IW-1:0] idle_r;

    // Fires in the cycle the idle count reaches TO; if the output is blocked
    // the count parks at TO and the flush happens as soon as room appears.
    assign idle_fire_s = (idle_r >= IW'(TO - 1)) && room_s;

    // Idle counter: counts RUN cycles without an accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_r <= '0;
        end else if (accept_s || (state_nxt_s != RUN)) begin
            idle_r <= '0;
        end else if (idle_r < IW'(TO)) begin
            idle_r <= idle_r + IW'(1);
        end else begin
            idle_r <= idle_r;
        end
    end
`else
    // TO has no function without the idle timeout; tie it to a named sink.
    logic [31:0] unused_to_s;
    assign unused_to_s = 32'(TO);
    assign idle_fire_s = 1'b0;
`endif

    // Control state and open-run register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= EMPTY;
            run_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            run_r   <= run_nxt_s;
        end
    end

    // Next-state and output-register load decisions.
    always_comb begin
        state_nxt_s = state_r;
        run_nxt_s   = run_r;
        or_load_s   = 1'b0;
        or_din_s    = '0;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    if (s_tlast) begin
                        or_load_s = 1'b1;
                        or_din_s  = '{val: s_tdata, cnt: CNT_ONE, last: 1'b1};
                    end else begin
                        run_nxt_s   = '{val: s_tdata, cnt: CNT_ONE, last: 1'b0};
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            RUN: begin
                if (accept_s) begin
                    if (s_tdata == run_r.val) begin
                        if (s_tlast) begin
                            or_load_s   = 1'b1;
                            or_din_s    = '{val: run_r.val, cnt: cnt_inc_s, last: 1'b1};
                            state_nxt_s = EMPTY;
                        end else if (cnt_inc_s == CNT_MAX) begin
                            // Saturation split: the next equal beat opens a new record.
                            or_load_s   = 1'b1;
                            or_din_s    = '{val: run_r.val, cnt: CNT_MAX, last: 1'b0};
                            state_nxt_s = EMPTY;
                        end else begin
                            run_nxt_s.cnt = cnt_inc_s;
                        end
                    end else begin
                        // Differing beat closes the run; a trailing tlast beat
                        // becomes its own record via CLOSE.
                        or_load_s   = 1'b1;
                        or_din_s    = '{val: run_r.val, cnt: run_r.cnt, last: 1'b0};
                        run_nxt_s   = '{val: s_tdata, cnt: CNT_ONE, last: s_tlast};
                        state_nxt_s = s_tlast ? CLOSE : RUN;
                    end
                end else if (idle_fire_s) begin
                    or_load_s   = 1'b1;
                    or_din_s    = '{val: run_r.val, cnt: run_r.cnt, last: 1'b0};
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            CLOSE: begin
                if (room_s) begin
                    or_load_s   = 1'b1;
                    or_din_s    = '{val: run_r.val, cnt: run_r.cnt, last: 1'b1};
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = CLOSE;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
                run_nxt_s   = '0;
            end
        endcase
    end

    str_reg_out #(
        .W(RW)
    ) u_reg_out (
        .clk      (clk),
        .rst      (rst),
        .load     (or_load_s),
        .din      (or_din_s),
        .m_tvalid (or_valid_s),
        .m_tready (m_tready),
        .dout     (or_dout_s)
    );

    assign m_tvalid = or_valid_s;
    assign m_tdata  = or_dout_s.val;
    assign m_tcnt   = or_dout_s.cnt;
    assign m_tlast  = or_dout_s.last;

endmodule
